// File: rtl/mem_wb_skid_stage_if.sv
// MEM->WB handshake bundle: upstream in_* side and downstream out_* side of the skid stage.
// The stage takes the slave view and the memory stage / register-file port take the master view.
interface mem_wb_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_mem_rdata;
  logic [REG_AW-1:0] in_dest;

  logic              out_valid;
  logic              out_ready;
  logic              out_reg_write;
  logic              out_mem_to_reg;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_mem_rdata;
  logic [REG_AW-1:0] out_dest;
  logic [DATA_W-1:0] out_wb_data;

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_result, in_mem_rdata, in_dest,
    input  in_ready,
    input  out_valid, out_reg_write, out_mem_to_reg, out_result, out_mem_rdata, out_dest,
    input  out_wb_data,
    output out_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_result, in_mem_rdata, in_dest,
    output in_ready,
    output out_valid, out_reg_write, out_mem_to_reg, out_result, out_mem_rdata, out_dest,
    output out_wb_data,
    input  out_ready
  );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage with a 2-entry skid buffer; 1-cycle latency, full throughput.
// in_ready drops only when both head and skid hold entries, so upstream stalls without loss.
module mem_wb_skid_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int ZERO_SUPP = 1
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  mem_wb_skid_stage_if.slave bus
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_AW-1:0] dest;
  } wb_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  wb_t    head_q, skid_q, in_bundle;
  logic   head_valid, fire, outfire;
  logic   load_head_in, load_head_skid, load_skid;

  assign head_valid   = (state_q != EMPTY);
  assign bus.in_ready = rst_n & (state_q != FULL);
  assign fire         = bus.in_valid & bus.in_ready;
  assign outfire      = head_valid & bus.out_ready;

  // R0 is hardwired, so a write to it is dropped at capture time.
  always_comb begin
    in_bundle           = '0;
    in_bundle.reg_write = bus.in_reg_write & ~((ZERO_SUPP != 0) && (bus.in_dest == '0));
    in_bundle.mem_to_reg = bus.in_mem_to_reg;
    in_bundle.result    = bus.in_result;
    in_bundle.mem_rdata = bus.in_mem_rdata;
    in_bundle.dest      = bus.in_dest;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (fire) begin
          load_head_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (fire && outfire) begin
          load_head_in = 1'b1;
        end else if (fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (outfire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (outfire) begin
          load_head_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only clears occupancy; data registers are left stale on purpose.
    if (flush) begin
      state_d        = EMPTY;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head_in) begin
        head_q <= in_bundle;
      end else if (load_head_skid) begin
        head_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_bundle;
      end
    end
  end

  assign bus.out_valid      = head_valid;
  assign bus.out_reg_write  = head_q.reg_write & head_valid;
  assign bus.out_mem_to_reg = head_q.mem_to_reg;
  assign bus.out_result     = head_q.result;
  assign bus.out_mem_rdata  = head_q.mem_rdata;
  assign bus.out_dest       = head_q.dest;
  assign bus.out_wb_data    = head_q.mem_to_reg ? head_q.mem_rdata : head_q.result;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: per-cycle vector table for occupancy/handshake,
// scoreboard queue for bundle ordering and contents.
module tb_mem_wb_skid_stage;

  logic clk;
  logic rst_n;
  logic flush;

  mem_wb_skid_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  mem_wb_skid_stage #(.DATA_W(32), .REG_AW(5), .ZERO_SUPP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        iv;
    logic        ordy;
    logic        rw;
    logic        m2r;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [31:0] rd;
    logic        eov;
    logic        eir;
    logic        eorw;
  } vec_t;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] res;
    logic [31:0] rd;
    logic [4:0]  dest;
    logic [31:0] wb;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input logic ordy,
                     input logic rw, input logic m2r, input logic [4:0] dest,
                     input logic [31:0] res, input logic [31:0] rd,
                     input logic eov, input logic eir, input logic eorw);
    vec_t v;
    v.rst_n = r;  v.flush = f;  v.iv = iv;  v.ordy = ordy;
    v.rw = rw;    v.m2r = m2r;  v.dest = dest;
    v.res = res;  v.rd = rd;
    v.eov = eov;  v.eir = eir;  v.eorw = eorw;
    vecs.push_back(v);
  endtask

  function automatic logic [127:0] pack_out();
    return {25'd0, bus.out_reg_write, bus.out_mem_to_reg, bus.out_result,
            bus.out_mem_rdata, bus.out_dest, bus.out_wb_data};
  endfunction

  function automatic logic [127:0] pack_exp(input exp_t e);
    return {25'd0, e.rw, e.m2r, e.res, e.rd, e.dest, e.wb};
  endfunction

  initial begin
    exp_t e;
    logic fire;
    logic outfire;
    n_tests = 0;
    n_fail  = 0;

    // stream: dest 1..8, result 0x10..0x17, load data never selected
    for (int i = 0; i < 8; i++)
      add(1, 0, 1, 1, 1, 0, 5'(i + 1), 32'h10 + i, 32'hF000_0000 | i, 1, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    // back-pressure: A, B fill, C held upstream until release
    add(1, 0, 1, 0, 1, 0, 3, 32'hA0, 32'h5A0, 1, 1, 1);
    add(1, 0, 1, 0, 1, 0, 4, 32'hB0, 32'h5B0, 1, 0, 1);
    add(1, 0, 1, 0, 1, 1, 5, 32'hC0, 32'h5C0, 1, 0, 1);
    add(1, 0, 1, 1, 1, 1, 5, 32'hC0, 32'h5C0, 1, 1, 1);
    add(1, 0, 1, 1, 1, 1, 5, 32'hC0, 32'h5C0, 1, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    // write-back mux and R0 suppression
    add(1, 0, 1, 0, 1, 1, 7, 32'h1, 32'hDEAD_BEEF, 1, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 1, 0, 0, 32'h55, 32'h66, 1, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    // flush while FULL with a concurrent input, then flush while EMPTY
    add(1, 0, 1, 0, 1, 0, 9, 32'h90, 32'h190, 1, 1, 1);
    add(1, 0, 1, 0, 1, 0, 10, 32'h91, 32'h191, 1, 0, 1);
    add(1, 1, 1, 0, 1, 0, 11, 32'h92, 32'h192, 0, 1, 0);
    add(1, 0, 1, 1, 1, 0, 12, 32'h93, 32'h193, 1, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 1, 1, 1, 0, 13, 32'h94, 32'h194, 0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    // reset while FULL, then first accept right after release
    add(1, 0, 1, 0, 1, 1, 14, 32'hE0, 32'hE1, 1, 1, 1);
    add(1, 0, 1, 0, 1, 0, 15, 32'hF0, 32'hF1, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0, 16, 32'h100, 32'h101, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 17, 32'h110, 32'h111, 1, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);

    // reset held 3 cycles with a valid input presented
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_reg_write = 1'b1;
    bus.in_mem_to_reg = 1'b1;
    bus.in_result = 32'h1234;
    bus.in_mem_rdata = 32'h5678;
    bus.in_dest = 5'd6;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(bus.out_valid), 128'd0);
    check("reset_in_ready", 128'(bus.in_ready), 128'd0);
    check("reset_out_fields", pack_out(), 128'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1;
    check("release_idle_out_valid", 128'(bus.out_valid), 128'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      flush = vecs[i].flush;
      bus.in_valid = vecs[i].iv;
      bus.out_ready = vecs[i].ordy;
      bus.in_reg_write = vecs[i].rw;
      bus.in_mem_to_reg = vecs[i].m2r;
      bus.in_dest = vecs[i].dest;
      bus.in_result = vecs[i].res;
      bus.in_mem_rdata = vecs[i].rd;
      #1;
      fire = bus.in_valid & bus.in_ready;
      outfire = bus.out_valid & bus.out_ready;
      if (outfire) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_out row %0d: dest %0d emitted, none expected", i, bus.out_dest);
        end else begin
          e = sb.pop_front();
          check($sformatf("sb_bundle row %0d", i), pack_out(), pack_exp(e));
        end
      end
      if (fire && vecs[i].rst_n && !vecs[i].flush) begin
        e.rw = vecs[i].rw & (vecs[i].dest != 5'd0);
        e.m2r = vecs[i].m2r;
        e.res = vecs[i].res;
        e.rd = vecs[i].rd;
        e.dest = vecs[i].dest;
        e.wb = vecs[i].m2r ? vecs[i].rd : vecs[i].res;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!vecs[i].rst_n || vecs[i].flush) sb.delete();
      check($sformatf("out_valid row %0d", i), 128'(bus.out_valid), 128'(vecs[i].eov));
      check($sformatf("in_ready row %0d", i), 128'(bus.in_ready), 128'(vecs[i].eir));
      check($sformatf("out_reg_write row %0d", i), 128'(bus.out_reg_write), 128'(vecs[i].eorw));
      if (!vecs[i].rst_n)
        check($sformatf("reset_fields row %0d", i), pack_out(), 128'd0);
    end

    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
